// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: decouples the IF stage from the ID stage.
// Issues one instruction-memory request at a time over a req/ack handshake,
// queues returned {pc, instruction} pairs in a small FIFO and hands them to ID
// over valid/ready. A flush (taken jump) discards buffered and in-flight work.
//
// Optional build macro IFB_BYPASS_EN: when the FIFO is empty, a response
// arriving in WAIT is presented to ID in the same cycle it is acknowledged.
//
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module if_fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [AW-1:0] inst_addr,
  input  logic          flush,
  output logic          if_stall,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [AW-1:0] imem_rdata,
  output logic          id_valid,
  output logic [AW-1:0] id_inst,
  output logic [AW-1:0] id_pc,
  input  logic          id_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t        state;
  state_t        state_nx;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [AW-1:0] inst_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];

  logic          fifo_empty;
  logic          accept;
  logic          ack_ok;
  logic          bypass;
  logic          push;
  logic          pop;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: one outstanding request; a flush without a response
  // parks in DROP until the orphaned response is absorbed.
  // NOTE: state_nx gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = WAIT;
      WAIT: begin
        if (imem_ack)   state_nx = IDLE;
        else if (flush) state_nx = DROP;
      end
      DROP: if (imem_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output and handshake decode, derived from the registered state and count.
  always_comb begin
    fifo_empty = (count == '0);
    accept     = (state == IDLE) && ce && !flush && (count < CW'(DEPTH));
    ack_ok     = (state == WAIT) && imem_ack && !flush;
`ifdef IFB_BYPASS_EN
    bypass     = ack_ok && fifo_empty;
`else
    bypass     = 1'b0;
`endif
    // A bypassed response that ID takes immediately never touches storage.
    push       = ack_ok && !(bypass && id_ready);
    pop        = !fifo_empty && id_ready;
    // Stall is dropped on flush so IF can load the jump target.
    if_stall   = !rst && ce && !accept && !flush;
    // The request stays up for the whole transaction, including DROP.
    imem_req   = (state != IDLE);
    id_valid   = !fifo_empty || bypass;
    id_inst    = bypass ? imem_rdata : inst_mem[rd_ptr];
    id_pc      = bypass ? imem_addr  : pc_mem[rd_ptr];
  end

  // Request address: captured on accept and held until the next accept.
  always_ff @(posedge clk) begin
    if (rst)         imem_addr <= '0;
    else if (accept) imem_addr <= inst_addr;
  end

  // FIFO storage: written at the tail on push.
  // NOTE: storage is reset because ID reads the head entry directly and the
  // head must show zero after reset; the array is tiny so this is cheap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (push) begin
      inst_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= imem_addr;
    end
  end

  // FIFO pointers and occupancy; flush empties the queue and wins over any
  // simultaneous push or pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// tb_if_fetch_buffer: directed self-checking bench for if_fetch_buffer.
// The bench plays both the IF stage and the instruction memory, cycle by
// cycle; expected values are written out by hand. Builds with or without
// IFB_BYPASS_EN, adjusting the ack-cycle expectations accordingly.
module tb_if_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] inst_addr;
  logic        flush;
  logic        if_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_ready;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_buffer #(.DEPTH(2), .AW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .inst_addr  (inst_addr),
    .flush      (flush),
    .if_stall   (if_stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .id_ready   (id_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Full fetch with an initially empty FIFO and id_ready=1: accept, nwait
  // wait cycles, then ack. Leaves the buffer IDLE.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data, input int nwait);
    ce = 1'b1; inst_addr = addr; imem_ack = 1'b0; #1;
    check("accept_no_stall", 32'(if_stall), 0);
    cyc();
    check("req_up", 32'(imem_req), 1);
    check("req_addr", imem_addr, addr);
    check("empty_in_wait", 32'(id_valid), 0);
    for (int i = 0; i < nwait; i++) begin
      check("wait_stall", 32'(if_stall), 1);
      cyc();
    end
    imem_ack = 1'b1; imem_rdata = data; #1;
    check("ack_stall", 32'(if_stall), 1);
`ifdef IFB_BYPASS_EN
    check("byp_valid", 32'(id_valid), 1);
    check("byp_pc", id_pc, addr);
    check("byp_inst", id_inst, data);
`else
    check("ack_cycle_valid", 32'(id_valid), 0);
`endif
    cyc();
    imem_ack = 1'b0; imem_rdata = '0; #1;
    check("req_down", 32'(imem_req), 0);
`ifdef IFB_BYPASS_EN
    check("byp_consumed", 32'(id_valid), 0);
`else
    check("deliver_valid", 32'(id_valid), 1);
    check("deliver_pc", id_pc, addr);
    check("deliver_inst", id_inst, data);
`endif
  endtask

  // Zero-wait fetch whose result is left in the FIFO (caller holds id_ready=0).
  task automatic fetch_hold(input logic [31:0] addr, input logic [31:0] data);
    ce = 1'b1; inst_addr = addr; imem_ack = 1'b0;
    cyc();
    check("hold_req", 32'(imem_req), 1);
    imem_ack = 1'b1; imem_rdata = data;
    cyc();
    imem_ack = 1'b0; imem_rdata = '0; ce = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; inst_addr = 32'h5; flush = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    #1;
    check("stall_in_reset", 32'(if_stall), 0);
    cyc();
    cyc();
    rst = 1'b0; ce = 1'b0; inst_addr = '0; #1;
    check("rst_req", 32'(imem_req), 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", 32'(id_valid), 0);
    check("rst_inst", id_inst, 0);
    check("rst_pc", id_pc, 0);

    // Straight-line fetch, one wait cycle per request.
    id_ready = 1'b1;
    fetch_one(32'h0, 32'h0000_0013, 1);
    fetch_one(32'h4, 32'h0010_0093, 1);
    fetch_one(32'h8, 32'h0020_0113, 1);
    ce = 1'b0;
    cyc();
    check("line_drained", 32'(id_valid), 0);

    // Back-pressure: two entries fill DEPTH=2, the third address is held.
    id_ready = 1'b0;
    fetch_hold(32'h0, 32'hA000_0001);
    fetch_hold(32'h4, 32'hB000_0002);
    ce = 1'b1; inst_addr = 32'h8; #1;
    check("full_stall", 32'(if_stall), 1);
    check("full_no_req", 32'(imem_req), 0);
    check("full_head_pc", id_pc, 32'h0);
    check("full_head_inst", id_inst, 32'hA000_0001);
    cyc();
    check("full_stall_held", 32'(if_stall), 1);
    check("full_no_req_held", 32'(imem_req), 0);
    id_ready = 1'b1;
    cyc();
    check("bp_second_valid", 32'(id_valid), 1);
    check("bp_second_pc", id_pc, 32'h4);
    check("bp_second_inst", id_inst, 32'hB000_0002);
    check("bp_unstall", 32'(if_stall), 0);
    cyc();
    check("bp_third_req", 32'(imem_req), 1);
    check("bp_third_addr", imem_addr, 32'h8);
    check("bp_empty", 32'(id_valid), 0);
    imem_ack = 1'b1; imem_rdata = 32'hC000_0003; #1;
`ifdef IFB_BYPASS_EN
    check("bp_third_byp_pc", id_pc, 32'h8);
    check("bp_third_byp_inst", id_inst, 32'hC000_0003);
`endif
    cyc();
    imem_ack = 1'b0; ce = 1'b0; #1;
`ifndef IFB_BYPASS_EN
    check("bp_third_pc", id_pc, 32'h8);
    check("bp_third_inst", id_inst, 32'hC000_0003);
    cyc();
`endif
    check("bp_drained", 32'(id_valid), 0);

    // Flush during WAIT: the late response must be absorbed in DROP.
    ce = 1'b1; inst_addr = 32'h10; #1;
    cyc();
    check("fl_req", 32'(imem_req), 1);
    check("fl_addr", imem_addr, 32'h10);
    flush = 1'b1; inst_addr = 32'h100; #1;
    check("fl_no_stall", 32'(if_stall), 0);
    cyc();
    flush = 1'b0; #1;
    check("drop_req", 32'(imem_req), 1);
    check("drop_stall", 32'(if_stall), 1);
    cyc();
    flush = 1'b1; #1;
    cyc();
    flush = 1'b0; #1;
    check("drop_reflush_req", 32'(imem_req), 1);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    check("drop_no_byp", 32'(id_valid), 0);
    cyc();
    imem_ack = 1'b0; imem_rdata = '0; ce = 1'b0; #1;
    check("drop_done_req", 32'(imem_req), 0);
    check("drop_discard", 32'(id_valid), 0);
    fetch_one(32'h100, 32'h0050_0293, 0);
    ce = 1'b0;
    cyc();
    check("fl_drained", 32'(id_valid), 0);

    // Flush coincident with ack and pop while one entry is buffered.
    id_ready = 1'b0;
    fetch_hold(32'h40, 32'h1111_1111);
    ce = 1'b1; inst_addr = 32'h44;
    cyc();
    check("co_head_valid", 32'(id_valid), 1);
    check("co_head_pc", id_pc, 32'h40);
    check("co_req", 32'(imem_req), 1);
    flush = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
    id_ready = 1'b1; inst_addr = 32'h200; #1;
    check("co_no_stall", 32'(if_stall), 0);
    cyc();
    flush = 1'b0; imem_ack = 1'b0; imem_rdata = '0; ce = 1'b0; #1;
    check("co_empty", 32'(id_valid), 0);
    check("co_req_down", 32'(imem_req), 0);
    cyc();
    check("co_not_pushed", 32'(id_valid), 0);

    // Synchronous reset while a request is pending and the FIFO holds data.
    id_ready = 1'b0;
    fetch_hold(32'h60, 32'h3333_3333);
    ce = 1'b1; inst_addr = 32'h80;
    cyc();
    check("rw_req", 32'(imem_req), 1);
    check("rw_valid", 32'(id_valid), 1);
    rst = 1'b1; #1;
    check("rw_stall_forced", 32'(if_stall), 0);
    cyc();
    rst = 1'b0; ce = 1'b0; #1;
    check("rw_req_cleared", 32'(imem_req), 0);
    check("rw_valid_cleared", 32'(id_valid), 0);
    check("rw_addr_cleared", imem_addr, 0);
    check("rw_pc_cleared", id_pc, 0);
    check("rw_inst_cleared", id_inst, 0);
    imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
    cyc();
    imem_ack = 1'b0; imem_rdata = '0; #1;
    check("rw_stale_ack_ignored", 32'(id_valid), 0);

    // Zero-wait fetch at 0x20 into an empty FIFO (bypass case when enabled).
    id_ready = 1'b1;
    fetch_one(32'h20, 32'h0000_0013, 0);
    ce = 1'b0;
    cyc();
    check("byp_final_empty", 32'(id_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
